// File: rtl/idex_hazard_reg.sv
// rtl/idex_hazard_reg.sv - ID/EX pipeline register with load-use hazard detection, bubble insertion and stall control
module idex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic [3:0]        id_aluop,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dst,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_alusrc,
  output logic [3:0]        ex_aluop,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              load_use,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              alusrc;
    logic [3:0]        aluop;
  } ex_t;

  ex_t              ex_q, ex_d, id_fields;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_hit, rt_hit, stall_front;

  always_comb begin
    rs_hit   = id_uses_rs & (id_rs == ex_q.dst);
    rt_hit   = id_uses_rt & (id_rt == ex_q.dst);
    load_use = ~reset & id_valid & ex_q.valid & ex_q.memread &
               (ex_q.dst != '0) & (rs_hit | rt_hit);
  end

  // Flush wins over load_use so a taken branch can still redirect the PC.
  assign stall_front = ex_stall | (load_use & ~flush);
  assign pc_write    = reset | ~stall_front;
  assign ifid_write  = reset | ~stall_front;

  always_comb begin
    id_fields          = '0;
    id_fields.valid    = 1'b1;
    id_fields.rs       = id_rs;
    id_fields.rt       = id_rt;
    id_fields.dst      = id_regdst ? id_rd : id_rt;
    id_fields.rs_data  = id_rs_data;
    id_fields.rt_data  = id_rt_data;
    id_fields.imm      = id_imm;
    id_fields.regwrite = id_regwrite;
    id_fields.memread  = id_memread;
    id_fields.memwrite = id_memwrite;
    id_fields.memtoreg = id_memtoreg;
    id_fields.alusrc   = id_alusrc;
    id_fields.aluop    = id_aluop;
  end

  // A bubble is all-zero so the forwarding unit can never match it.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (!ex_stall) begin
      if (flush || load_use || !id_valid) begin
        ex_d = '0;
      end else begin
        ex_d = id_fields;
      end
      if (load_use && !flush && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_dst      = ex_q.dst;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm      = ex_q.imm;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_aluop    = ex_q.aluop;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_idex_hazard_reg.sv
// tb/tb_idex_hazard_reg.sv - vector table, corner sequences and random model check for idex_hazard_reg
module tb_idex_hazard_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, id_valid, id_uses_rs, id_uses_rt;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic          id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst;
  logic [3:0]    id_aluop;
  logic          flush, ex_stall;
  logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic [AW-1:0] ex_rs, ex_rt, ex_dst;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [3:0]    ex_aluop;
  logic          pc_write, ifid_write, load_use;
  logic [CW-1:0] bubble_cnt;

  idex_hazard_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_aluop(id_aluop), .flush(flush),
    .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .pc_write(pc_write), .ifid_write(ifid_write), .load_use(load_use), .bubble_cnt(bubble_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic reset, valid;
    logic [4:0] rs, rt, rd;
    logic urs, urt, regdst, regwrite, memread, memwrite, memtoreg, alusrc;
    logic [3:0] aluop;
    logic [31:0] rs_data, rt_data, imm;
    logic flush, stall;
  } in_t;

  typedef struct {
    in_t i;
    logic lu, pcw, v;
    logic [4:0] ers, edst;
    logic emr, erw;
    logic [3:0] cnt;
    logic [31:0] edata, eimm;
  } vec_t;

  typedef struct {
    logic valid;
    logic [4:0] rs, rt, dst;
    logic [31:0] rs_data, rt_data, imm;
    logic regwrite, memread, memwrite, memtoreg, alusrc;
    logic [3:0] aluop;
  } ex_t;

  ex_t  m;
  int   m_cnt = 0;
  logic m_lu_s, lu_s, pcw_s, ifw_s;

  function automatic in_t mk_in(input int rst, iv, rs, rt, rd, urs, urt, rdst, rw, mr, fl, st,
                                input int data, imm);
    in_t x;
    x.reset = rst[0]; x.valid = iv[0]; x.rs = rs[4:0]; x.rt = rt[4:0]; x.rd = rd[4:0];
    x.urs = urs[0]; x.urt = urt[0]; x.regdst = rdst[0]; x.regwrite = rw[0]; x.memread = mr[0];
    x.memwrite = 1'b0; x.memtoreg = 1'b0; x.alusrc = 1'b0; x.aluop = 4'h3;
    x.rs_data = data; x.rt_data = 32'h1234_5678; x.imm = imm;
    x.flush = fl[0]; x.stall = st[0];
    return x;
  endfunction

  function automatic vec_t row(input int rst, iv, rs, rt, rd, urs, urt, rdst, rw, mr, fl, st,
                               input int data, imm, input int lu, pcw, v, ers, edst, emr, erw, cnt,
                               input int edata, eimm);
    vec_t r;
    r.i = mk_in(rst, iv, rs, rt, rd, urs, urt, rdst, rw, mr, fl, st, data, imm);
    r.lu = lu[0]; r.pcw = pcw[0]; r.v = v[0]; r.ers = ers[4:0]; r.edst = edst[4:0];
    r.emr = emr[0]; r.erw = erw[0]; r.cnt = cnt[3:0]; r.edata = edata; r.eimm = eimm;
    return r;
  endfunction

  function automatic logic model_lu(input in_t x, input ex_t e);
    if (x.reset || !x.valid || !e.valid || !e.memread || e.dst == 5'd0) return 1'b0;
    return (x.urs && x.rs == e.dst) || (x.urt && x.rt == e.dst);
  endfunction

  task automatic model_step(input in_t x, input logic lu);
    if (x.reset) begin
      m = '{default: '0};
      m_cnt = 0;
    end else if (x.stall) begin
      m = m;
    end else if (x.flush || lu || !x.valid) begin
      m = '{default: '0};
      if (lu && !x.flush) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end else begin
      m.valid = 1'b1; m.rs = x.rs; m.rt = x.rt; m.dst = x.regdst ? x.rd : x.rt;
      m.rs_data = x.rs_data; m.rt_data = x.rt_data; m.imm = x.imm;
      m.regwrite = x.regwrite; m.memread = x.memread; m.memwrite = x.memwrite;
      m.memtoreg = x.memtoreg; m.alusrc = x.alusrc; m.aluop = x.aluop;
    end
  endtask

  task automatic drive(input in_t x);
    reset = x.reset; id_valid = x.valid; id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
    id_uses_rs = x.urs; id_uses_rt = x.urt; id_regdst = x.regdst; id_regwrite = x.regwrite;
    id_memread = x.memread; id_memwrite = x.memwrite; id_memtoreg = x.memtoreg;
    id_alusrc = x.alusrc; id_aluop = x.aluop; id_rs_data = x.rs_data; id_rt_data = x.rt_data;
    id_imm = x.imm; flush = x.flush; ex_stall = x.stall;
  endtask

  // Called at a negedge; returns at the next negedge with the new EX state visible.
  task automatic cycle(input in_t x);
    drive(x);
    #1;
    lu_s = load_use; pcw_s = pc_write; ifw_s = ifid_write;
    m_lu_s = model_lu(x, m);
    @(posedge clk);
    model_step(x, m_lu_s);
    @(negedge clk);
  endtask

  vec_t tbl[19];
  in_t  lw5, add5, rx;
  logic exp_pcw;

  initial begin
    m = '{default: '0};
    tbl[0]  = row(1,1,5,0,0,1,0,0,1,1,0,0, 'h99,'h99,  0,1,0,0,0,0,0,0,0,0);
    tbl[1]  = row(0,1,1,5,0,1,0,0,1,1,0,0, 100,4,      0,1,1,1,5,1,1,0,100,4);
    tbl[2]  = row(0,1,5,2,6,1,1,1,1,0,0,0, 200,0,      1,0,0,0,0,0,0,1,0,0);
    tbl[3]  = row(0,1,5,2,6,1,1,1,1,0,0,0, 200,0,      0,1,1,5,6,0,1,1,200,0);
    tbl[4]  = row(0,1,0,0,0,1,0,0,1,1,0,0, 0,8,        0,1,1,0,0,1,1,1,0,8);
    tbl[5]  = row(0,1,0,3,4,1,1,1,1,0,0,0, 7,0,        0,1,1,0,4,0,1,1,7,0);
    tbl[6]  = row(0,1,2,7,0,1,0,0,1,1,0,0, 9,12,       0,1,1,2,7,1,1,1,9,12);
    tbl[7]  = row(0,1,1,7,9,1,0,1,1,0,0,0, 'hDEADBEEF,'hDEADBEEF, 0,1,1,1,9,0,1,1,'hDEADBEEF,'hDEADBEEF);
    tbl[8]  = row(0,1,1,3,9,0,0,0,1,1,0,0, 5,6,        0,1,1,1,3,1,1,1,5,6);
    tbl[9]  = row(0,1,3,0,0,1,0,0,1,0,1,0, 1,1,        1,1,0,0,0,0,0,1,0,0);
    tbl[10] = row(0,1,4,8,0,1,0,0,1,1,0,0, 'h11,'h22,  0,1,1,4,8,1,1,1,'h11,'h22);
    tbl[11] = row(0,1,8,0,0,1,0,0,1,0,0,1, 'h30,0,     1,0,1,4,8,1,1,1,'h11,'h22);
    tbl[12] = row(0,1,9,10,11,1,1,1,1,0,0,1,'h33,'h44, 0,0,1,4,8,1,1,1,'h11,'h22);
    tbl[13] = row(0,0,8,8,0,1,1,0,1,0,0,1, 0,0,        0,0,1,4,8,1,1,1,'h11,'h22);
    tbl[14] = row(0,1,1,2,12,1,1,1,1,0,0,0,'h55,'h66,  0,1,1,1,12,0,1,1,'h55,'h66);
    tbl[15] = row(0,0,3,4,5,1,0,1,1,1,0,0, 'h77,0,     0,1,0,0,0,0,0,1,0,0);
    tbl[16] = row(0,1,0,5,0,0,0,0,1,1,0,0, 1,2,        0,1,1,0,5,1,1,1,1,2);
    tbl[17] = row(0,1,5,0,0,1,0,0,1,0,0,1, 3,3,        1,0,1,0,5,1,1,1,1,2);
    tbl[18] = row(1,1,5,0,0,1,0,0,1,0,0,1, 3,3,        0,1,0,0,0,0,0,0,0,0);

    @(negedge clk);
    for (int r = 0; r < 19; r++) begin
      cycle(tbl[r].i);
      check($sformatf("row%0d_load_use", r), lu_s, tbl[r].lu);
      check($sformatf("row%0d_pc_write", r), pcw_s, tbl[r].pcw);
      check($sformatf("row%0d_ifid_write", r), ifw_s, tbl[r].pcw);
      check($sformatf("row%0d_ex_valid", r), ex_valid, tbl[r].v);
      check($sformatf("row%0d_ex_rs", r), ex_rs, tbl[r].ers);
      check($sformatf("row%0d_ex_dst", r), ex_dst, tbl[r].edst);
      check($sformatf("row%0d_ex_memread", r), ex_memread, tbl[r].emr);
      check($sformatf("row%0d_ex_regwrite", r), ex_regwrite, tbl[r].erw);
      check($sformatf("row%0d_bubble_cnt", r), bubble_cnt, tbl[r].cnt);
      check($sformatf("row%0d_ex_rs_data", r), ex_rs_data, tbl[r].edata);
      check($sformatf("row%0d_ex_imm", r), ex_imm, tbl[r].eimm);
    end

    lw5  = mk_in(0,1,0,5,0,0,0,0,1,1,0,0, 1,2);
    add5 = mk_in(0,1,5,2,6,1,1,1,1,0,0,0, 3,0);
    for (int i = 0; i < 17; i++) begin
      cycle(lw5);
      cycle(add5);
      check($sformatf("sat%0d_load_use", i), lu_s, 1'b1);
      check($sformatf("sat%0d_bubble_cnt", i), bubble_cnt, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
    end
    cycle(lw5);
    check("pre_reset_ex_valid", ex_valid, 1'b1);
    add5.reset = 1'b1;
    cycle(add5);
    add5.reset = 1'b0;
    check("mid_reset_ex_state", {ex_valid, ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread}, '0);
    check("mid_reset_operands", {ex_rs_data, ex_imm}, '0);
    check("mid_reset_bubble_cnt", bubble_cnt, '0);

    for (int i = 0; i < 800; i++) begin
      rx.reset = ($urandom_range(0, 49) == 0);
      rx.valid = ($urandom_range(0, 7) != 0);
      rx.rs = 5'($urandom_range(0, 7));
      rx.rt = 5'($urandom_range(0, 7));
      rx.rd = 5'($urandom_range(0, 7));
      rx.urs = 1'($urandom_range(0, 1));
      rx.urt = 1'($urandom_range(0, 1));
      rx.regdst = 1'($urandom_range(0, 1));
      rx.regwrite = 1'($urandom_range(0, 1));
      rx.memread = 1'($urandom_range(0, 1));
      rx.memwrite = 1'($urandom_range(0, 1));
      rx.memtoreg = 1'($urandom_range(0, 1));
      rx.alusrc = 1'($urandom_range(0, 1));
      rx.aluop = 4'($urandom);
      rx.rs_data = $urandom;
      rx.rt_data = $urandom;
      rx.imm = $urandom;
      rx.flush = ($urandom_range(0, 9) == 0);
      rx.stall = ($urandom_range(0, 6) == 0);
      cycle(rx);
      exp_pcw = rx.reset ? 1'b1 : !(rx.stall || (m_lu_s && !rx.flush));
      check($sformatf("rnd%0d_comb", i), {lu_s, pcw_s, ifw_s}, {m_lu_s, exp_pcw, exp_pcw});
      check($sformatf("rnd%0d_ctl", i),
            {ex_valid, ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
             ex_alusrc, ex_aluop},
            {m.valid, m.rs, m.rt, m.dst, m.regwrite, m.memread, m.memwrite, m.memtoreg,
             m.alusrc, m.aluop});
      check($sformatf("rnd%0d_data", i), {ex_rs_data, ex_rt_data}, {m.rs_data, m.rt_data});
      check($sformatf("rnd%0d_imm", i), ex_imm, m.imm);
      check($sformatf("rnd%0d_bubble_cnt", i), bubble_cnt, m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/idex_hazard_reg.md
Name: idex_hazard_reg

Overview:
- ID/EX pipeline register combined with load-use hazard detection for the 5-stage pipeline.
- Captures decoded operands, register specifiers and control from ID and presents them to EX and to the forwarding unit (rs/rt/dst, regwrite).
- Detects load-use hazards that forwarding cannot resolve, stalls PC and IF/ID, and inserts bubbles.
- Handles branch flush and external (memory) stall.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register specifier width
CNT_W, 16, width of load-use bubble counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_AW  source register 1 specifier
id_rt  in  REG_AW  source register 2 specifier
id_rd  in  REG_AW  R-type destination specifier
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_rs_data  in  DATA_W  register file read data 1
id_rt_data  in  DATA_W  register file read data 2
id_imm  in  DATA_W  sign-extended immediate
id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst  in  1 each  decoded control
id_aluop  in  4  ALU operation
flush  in  1  branch/jump taken; kill the instruction in ID
ex_stall  in  1  downstream stall; freeze the pipeline
ex_valid  out  1  EX holds a real instruction
ex_rs, ex_rt  out  REG_AW  registered specifiers (forwarding unit IDEX_rs/IDEX_rt)
ex_dst  out  REG_AW  registered destination: id_regdst ? id_rd : id_rt
ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands
ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc  out  1 each  registered control
ex_aluop  out  4  registered ALU op
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
load_use  out  1  combinational hazard indication
bubble_cnt  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- Reset value of all registered outputs, bubble_cnt included, is 0. ex_valid=0.
- Hazard equation (combinational from current ex_* state and id_* inputs):
  load_use = id_valid & ex_valid & ex_memread & (ex_dst!=0) & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)).
- While reset=1, load_use is forced to 0.
- Register update priority at each rising edge:
  - reset: clear all registers.
  - ex_stall: hold every ex_* register; bubble_cnt unchanged.
  - flush: load a bubble.
  - load_use: load a bubble; bubble_cnt += 1, saturating at all-ones.
  - otherwise: load ID fields. ex_valid = id_valid; control bits gated by id_valid (id_valid=0 loads a bubble).
- Bubble definition:
  - ex_valid=0; regwrite, memread, memwrite, memtoreg all 0.
  - ex_rs, ex_rt, ex_dst = 0, so the forwarding unit never matches a bubble.
  - Data, imm, alusrc and aluop fields = 0.
- Stall outputs (combinational):
  - pc_write = ifid_write = ~(ex_stall | (load_use & ~flush)).
  - Flush overrides load_use so the redirect proceeds.
  - ex_stall overrides everything; during reset both are 1.
- Latency: one cycle, ID → EX. A load-use hazard costs exactly one bubble. On the next cycle the load sits in MEM and the dependent instruction is re-presented with ex_memread=0 from the bubble, so load_use deasserts.
- Simultaneous flush & load_use: a single bubble is loaded and bubble_cnt is not incremented.
- Simultaneous ex_stall & load_use: hold; no count. The hazard is re-evaluated after the stall releases.
- Reset mid-stall: registers clear on that edge; no count.

Test Plan:
- Hazard and bubble: lw r5 in EX (ex_memread=1, ex_dst=5), ID add with rs=5, uses_rs=1 → load_use=1, pc_write=0, ifid_write=0. Next cycle ex_valid=0, ex_regwrite=0, ex_dst=0, bubble_cnt=1. Following cycle the add loads with ex_rs=5.
- No false hazards:
  - ex_dst=0 with memread=1 and id_rs=0 → load_use=0.
  - id_uses_rt=0 with id_rt==ex_dst=7 → load_use=0; instruction loads next edge.
- Regdst selection: id_regdst=1, id_rd=9, id_rt=3 → ex_dst=9. id_regdst=0 → ex_dst=3. Data and imm (e.g. 0xDEADBEEF) appear unchanged one cycle later.
- Flush priority: flush=1 together with load_use=1 → pc_write=1, bubble loaded, bubble_cnt unchanged.
- External stall: ex_stall=1 for 3 cycles with changing id_* → ex_* constant, pc_write=0. On release the pending ID instruction loads.
- Counter saturation and reset:
  - With CNT_W=4, trigger 17 load-use bubbles → bubble_cnt=15.
  - Assert reset mid-sequence → all ex_* and bubble_cnt=0 the next cycle.
